// File: rtl/gyro_rx_pkg.sv
// Shared definitions for the gyro serial-link receive deframer.
// Holds the word width, the default sizing parameters and the deframer state encoding.
// Imported by the stream interface, the word FIFO and the deframer top.
package gyro_rx_pkg;

    localparam int WORD_W         = 32;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_CNT_W      = 16;

    // IDLE waits for a dsync-marked bit, SHIFT collects the remaining 31 bits.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/gyro_rx_deframer_if.sv
// Word stream from the deframer FIFO towards the capture/DMA path.
// Latency: n/a (wiring only).
// Backpressure: m_ready from the consumer; a word moves on a cycle with m_valid & m_ready.
//   master : drives m_data / m_valid, samples m_ready
//   slave  : samples m_data / m_valid, drives m_ready
interface gyro_rx_deframer_if;
    import gyro_rx_pkg::*;

    logic [WORD_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/gyro_word_fifo.sv
// Synchronous word FIFO with a registered head word, occupancy level and flush.
// Latency: a word pushed into an empty FIFO appears on out_vld/out_dat one cycle after the push edge.
// Backpressure: push while full is dropped (drop pulses) unless a pop happens in the same cycle.
//   ACLK/ARESET : clock, synchronous active-high reset
//   flush       : empties the FIFO, overrides push and pop in that cycle
//   push_vld/push_dat : write request (no ready; the full case is reported on drop)
//   pop_rdy     : consumer accept for out_vld/out_dat
//   level       : registered occupancy, 0..DEPTH
module gyro_word_fifo
    import gyro_rx_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       flush,
    input  logic                       push_vld,
    input  logic [WORD_W-1:0]          push_dat,
    output logic                       drop,
    input  logic                       pop_rdy,
    output logic                       out_vld,
    output logic [WORD_W-1:0]          out_dat,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW-1:0]     rd_nxt;
    logic [LW-1:0]     level_q;
    logic              out_vld_q;
    logic [WORD_W-1:0] out_dat_q;

    logic full;
    logic pop;
    logic push_acc;

    assign full     = (level_q == LW'(DEPTH));
    assign pop      = out_vld_q & pop_rdy & ~flush;
    // A pop frees the slot the push lands in, so full+pop still accepts.
    assign push_acc = push_vld & ~flush & (~full | pop);
    assign drop     = push_vld & ~flush & full & ~pop;
    assign rd_nxt   = rd_ptr_q + AW'(1);

    always_ff @(posedge ACLK) begin
        if (push_acc) begin
            mem[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else if (flush) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            out_vld_q <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_nxt;
            end
            if (push_acc && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push_acc) begin
                level_q <= level_q - LW'(1);
            end

            // The head register mirrors mem[rd_ptr_q]. On a pop the next entry is
            // prefetched only if it was already stored before this edge; a word
            // being written on this very edge is picked up one cycle later.
            if (pop) begin
                out_vld_q <= (level_q > LW'(1));
                if (level_q > LW'(1)) begin
                    out_dat_q <= mem[rd_nxt];
                end
            end else if (!out_vld_q && level_q != '0) begin
                out_vld_q <= 1'b1;
                out_dat_q <= mem[rd_ptr_q];
            end
        end
    end

    assign out_vld = out_vld_q;
    assign out_dat = out_dat_q;
    assign level   = level_q;

endmodule

// File: rtl/gyro_rx_deframer.sv
// Gyro link receive deframer: samples drx/dsync on bit_en, builds 32-bit MSB-first words, queues them.
// Latency: word pushed on the edge ending the 32nd bit_en cycle; m_valid 2 cycles after that cycle.
// Backpressure: m_ready stalls the FIFO head; words arriving while full are dropped and flag overflow.
//   ACLK/ARESET  : clock, synchronous active-high reset
//   enable       : run enable, low holds IDLE and discards a partial word
//   flush        : empties the FIFO and aborts the current frame
//   clr_status   : zeroes counters, overflow and the pattern checker seed
//   bit_en, drx, dsync : bit strobe and synchronized serial inputs
//   m            : word stream (m_data / m_valid / m_ready)
//   fifo_level, overflow, frame_cnt, sync_err_cnt, pat_err_cnt, pat_locked : status
// Optional incrementing-pattern checker: define GYRO_RX_PAT_CHECK_EN.
module gyro_rx_deframer
    import gyro_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          enable,
    input  logic                          flush,
    input  logic                          clr_status,
    input  logic                          bit_en,
    input  logic                          drx,
    input  logic                          dsync,
    gyro_rx_deframer_if.master            m,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [CNT_W-1:0]              frame_cnt,
    output logic [CNT_W-1:0]              sync_err_cnt,
    output logic [CNT_W-1:0]              pat_err_cnt,
    output logic                          pat_locked
);

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_SHIFT = SHIFT;

    logic [0:0]        state_q;
    logic [5:0]        bit_cnt_q;
    logic [WORD_W-1:0] shreg_q;
    logic              overflow_q;
    logic [CNT_W-1:0]  frame_cnt_q;
    logic [CNT_W-1:0]  sync_err_q;

    logic              run;
    logic              frame_done;
    logic              sync_err;
    logic [WORD_W-1:0] word_dat;
    logic              fifo_drop;
    logic              fifo_vld;
    logic [WORD_W-1:0] fifo_dat;

    assign run        = enable & ~flush;
    // bit_cnt_q counts bits already collected, so 31 here means this strobe is bit 32.
    assign frame_done = run & bit_en & ~dsync & (state_q == ST_SHIFT) & (bit_cnt_q == 6'd31);
    assign sync_err   = run & bit_en & dsync & (state_q == ST_SHIFT);
    assign word_dat   = {shreg_q[WORD_W-2:0], drx};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else if (!run) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
        end else if (bit_en) begin
            if (dsync) begin
                // Frame start, or resync of a truncated frame: this bit is the new MSB.
                state_q   <= ST_SHIFT;
                bit_cnt_q <= 6'd1;
                shreg_q   <= {{(WORD_W-1){1'b0}}, drx};
            end else if (state_q == ST_SHIFT) begin
                shreg_q <= word_dat;
                if (bit_cnt_q == 6'd31) begin
                    state_q   <= ST_IDLE;
                    bit_cnt_q <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 6'd1;
                end
            end
        end
    end

    // Status: clear beats a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge ACLK) begin
        if (ARESET || clr_status) begin
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
            sync_err_q  <= '0;
        end else begin
            if (fifo_drop) begin
                overflow_q <= 1'b1;
            end
            if (frame_done && frame_cnt_q != '1) begin
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
            if (sync_err && sync_err_q != '1) begin
                sync_err_q <= sync_err_q + CNT_W'(1);
            end
        end
    end

    gyro_word_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .flush    (flush),
        .push_vld (frame_done),
        .push_dat (word_dat),
        .drop     (fifo_drop),
        .pop_rdy  (m.m_ready),
        .out_vld  (fifo_vld),
        .out_dat  (fifo_dat),
        .level    (fifo_level)
    );

    assign m.m_valid    = fifo_vld;
    assign m.m_data     = fifo_dat;
    assign overflow     = overflow_q;
    assign frame_cnt    = frame_cnt_q;
    assign sync_err_cnt = sync_err_q;

`ifdef GYRO_RX_PAT_CHECK_EN
    logic              pat_check;
    logic [WORD_W-1:0] pat_exp_q;
    logic              pat_locked_q;
    logic [CNT_W-1:0]  pat_err_q;

    // Only words that actually enter the FIFO are checked.
    assign pat_check = frame_done & ~fifo_drop;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            pat_exp_q    <= '0;
            pat_locked_q <= 1'b0;
            pat_err_q    <= '0;
        end else begin
            if (clr_status) begin
                pat_err_q <= '0;
            end else if (pat_check && pat_locked_q && word_dat != pat_exp_q
                         && pat_err_q != '1) begin
                pat_err_q <= pat_err_q + CNT_W'(1);
            end

            // Every checked word (re)seeds the expectation; the +1 wraps naturally.
            if (clr_status || flush) begin
                pat_locked_q <= 1'b0;
            end else if (pat_check) begin
                pat_locked_q <= 1'b1;
                pat_exp_q    <= word_dat + WORD_W'(1);
            end
        end
    end

    assign pat_err_cnt = pat_err_q;
    assign pat_locked  = pat_locked_q;
`else
    assign pat_err_cnt = '0;
    assign pat_locked  = 1'b0;
`endif

endmodule

// File: tb/tb_gyro_rx_deframer.sv
// Randomized bench for gyro_rx_deframer against a word-level scoreboard model.
// Latency: n/a.
// Backpressure: m_ready is driven by the bench (held, pulsed or random).
module tb_gyro_rx_deframer;

    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int SATV  = (1 << CW) - 1;

    logic          tb_ACLK = 1'b0;
    logic          ARESET;
    logic          enable;
    logic          flush;
    logic          clr_status;
    logic          bit_en;
    logic          drx;
    logic          dsync;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] sync_err_cnt;
    logic [CW-1:0] pat_err_cnt;
    logic          pat_locked;

    gyro_rx_deframer_if u_if ();

    gyro_rx_deframer #(
        .FIFO_DEPTH   (DEPTH),
        .CNT_W        (CW)
    ) dut (
        .ACLK         (tb_ACLK),
        .ARESET       (ARESET),
        .enable       (enable),
        .flush        (flush),
        .clr_status   (clr_status),
        .bit_en       (bit_en),
        .drx          (drx),
        .dsync        (dsync),
        .m            (u_if),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .frame_cnt    (frame_cnt),
        .sync_err_cnt (sync_err_cnt),
        .pat_err_cnt  (pat_err_cnt),
        .pat_locked   (pat_locked)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: words expected out of the stream, in order, plus raw event counts.
    logic [31:0] exp_q[$];
    int          m_frames, m_sync, m_pat_err;
    bit          m_ovf, m_locked, m_in_frame;
    logic [31:0] m_pat_exp;
    bit          rnd_rdy;

    function automatic logic [63:0] sat(input int v);
        return (v > SATV) ? 64'(SATV) : 64'(v);
    endfunction

    // Scoreboard: every accepted word must be the oldest one the model expects.
    always @(negedge tb_ACLK) begin
        if (!ARESET && !flush && u_if.m_valid && u_if.m_ready) begin
            check_val("pop_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check_val("pop_data", u_if.m_data, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge tb_ACLK);
        #1;
        if (rnd_rdy) u_if.m_ready = 1'($urandom_range(0, 1));
    endtask

    // drx/dsync are randomized between strobes: they must only matter on bit_en.
    task automatic send_bit(input logic s, input logic d, input int gap);
        bit_en = 1'b1;
        dsync  = s;
        drx    = d;
        step();
        bit_en = 1'b0;
        dsync  = 1'($urandom_range(0, 1));
        drx    = 1'($urandom_range(0, 1));
        repeat (gap) step();
    endtask

    // Sends the first nbits of w MSB-first, dsync on the first bit; no gap after the last bit.
    task automatic send_frame(input logic [31:0] w, input int nbits, input int gmin,
                              input int gmax, input bit rdy_last);
        if (m_in_frame) m_sync++;
        for (int i = 0; i < nbits; i++) begin
            if (i == 31) begin
                if (rdy_last) u_if.m_ready = 1'b1;
                m_frames++;
                if (exp_q.size() < DEPTH || u_if.m_ready) begin
                    exp_q.push_back(w);
`ifdef GYRO_RX_PAT_CHECK_EN
                    if (m_locked && w != m_pat_exp) m_pat_err++;
                    m_locked  = 1'b1;
                    m_pat_exp = w + 32'd1;
`endif
                end else begin
                    m_ovf = 1'b1;
                end
                m_in_frame = 1'b0;
            end else begin
                m_in_frame = 1'b1;
            end
            send_bit(i == 0, w[31-i], (i == nbits - 1) ? 0 : $urandom_range(gmin, gmax));
            if (i == 31 && rdy_last) u_if.m_ready = 1'b0;
        end
    endtask

    task automatic do_clr();
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        m_frames = 0; m_sync = 0; m_pat_err = 0; m_ovf = 1'b0; m_locked = 1'b0;
    endtask

    task automatic do_flush();
        u_if.m_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_q.delete();
        m_in_frame = 1'b0;
        m_locked   = 1'b0;
    endtask

    task automatic do_reset();
        u_if.m_ready = 1'b0;
        ARESET = 1'b1;
        bit_en = 1'b0;
        repeat (3) step();
        ARESET = 1'b0;
        exp_q.delete();
        m_frames = 0; m_sync = 0; m_pat_err = 0;
        m_ovf = 1'b0; m_locked = 1'b0; m_in_frame = 1'b0;
    endtask

    task automatic drain(input string p);
        rnd_rdy = 1'b0;
        u_if.m_ready = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
        repeat (3) step();
        u_if.m_ready = 1'b0;
        @(negedge tb_ACLK);
        check_val({p, "_words_left"}, 64'(exp_q.size()), 64'd0);
        check_val({p, "_level_empty"}, 64'(fifo_level), 64'd0);
        check_val({p, "_valid_empty"}, 64'(u_if.m_valid), 64'd0);
    endtask

    task automatic check_status(input string p);
        @(negedge tb_ACLK);
        check_val({p, "_frame_cnt"}, 64'(frame_cnt), sat(m_frames));
        check_val({p, "_sync_err_cnt"}, 64'(sync_err_cnt), sat(m_sync));
        check_val({p, "_overflow"}, 64'(overflow), 64'(m_ovf));
        check_val({p, "_pat_err_cnt"}, 64'(pat_err_cnt), sat(m_pat_err));
        check_val({p, "_pat_locked"}, 64'(pat_locked), 64'(m_locked));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] seq;
        int r;
        ARESET = 1'b1; enable = 1'b1; flush = 1'b0; clr_status = 1'b0;
        bit_en = 1'b0; drx = 1'b0; dsync = 1'b0; u_if.m_ready = 1'b0; rnd_rdy = 1'b0;
        m_frames = 0; m_sync = 0; m_pat_err = 0; m_ovf = 1'b0; m_locked = 1'b0;
        m_in_frame = 1'b0; m_pat_exp = '0;
        repeat (3) step();
        ARESET = 1'b0;

        // Reset state
        @(negedge tb_ACLK);
        check_val("rst_m_valid", 64'(u_if.m_valid), 64'd0);
        check_val("rst_m_data", 64'(u_if.m_data), 64'd0);
        check_val("rst_level", 64'(fifo_level), 64'd0);
        check_status("rst");

        // Single frame, strobe every 4 cycles, head valid 2 cycles after bit 32
        step();
        send_frame(32'hA5C3_0F1E, 32, 3, 3, 1'b0);
        @(negedge tb_ACLK);
        check_val("lat_valid_plus1", 64'(u_if.m_valid), 64'd0);
        step();
        @(negedge tb_ACLK);
        check_val("lat_valid_plus2", 64'(u_if.m_valid), 64'd1);
        check_val("lat_data", 64'(u_if.m_data), 64'hA5C3_0F1E);
        check_val("single_level", 64'(fifo_level), 64'd1);
        check_val("single_frame_cnt", 64'(frame_cnt), 64'd1);
        drain("single");

        // Truncated frame followed by a full one
        do_clr();
        send_frame($urandom, 20, 0, 2, 1'b0);
        send_frame(32'h1234_5678, 32, 0, 2, 1'b0);
        drain("trunc");
        check_status("trunc");
        check_val("trunc_sync_err", 64'(sync_err_cnt), 64'd1);

        // Ten back-to-back frames into a stalled FIFO
        do_clr();
        for (int i = 0; i < 10; i++) send_frame($urandom, 32, 0, 0, 1'b0);
        repeat (3) step();
        @(negedge tb_ACLK);
        check_val("ovf_level", 64'(fifo_level), 64'd8);
        check_val("ovf_flag", 64'(overflow), 64'd1);
        check_status("ovf");

        // Full FIFO with push and pop on the same edge
        do_clr();
        send_frame($urandom, 32, 0, 2, 1'b1);
        repeat (3) step();
        @(negedge tb_ACLK);
        check_val("fullpp_level", 64'(fifo_level), 64'd8);
        check_val("fullpp_overflow", 64'(overflow), 64'd0);
        drain("fullpp");

        // Incrementing pattern with one gap
        do_clr();
        send_frame(32'd5, 32, 0, 1, 1'b0);
        send_frame(32'd6, 32, 0, 1, 1'b0);
        send_frame(32'd7, 32, 0, 1, 1'b0);
        send_frame(32'd9, 32, 0, 1, 1'b0);
        send_frame(32'd10, 32, 0, 1, 1'b0);
        drain("pat");
        check_status("pat");
`ifdef GYRO_RX_PAT_CHECK_EN
        check_val("pat_err_one", 64'(pat_err_cnt), 64'd1);
`else
        check_val("pat_err_zero", 64'(pat_err_cnt), 64'd0);
`endif

        // Flush mid-frame with three words queued
        do_clr();
        for (int i = 0; i < 3; i++) send_frame($urandom, 32, 0, 1, 1'b0);
        send_frame($urandom, 12, 0, 1, 1'b0);
        do_flush();
        @(negedge tb_ACLK);
        check_val("flush_level", 64'(fifo_level), 64'd0);
        check_val("flush_valid", 64'(u_if.m_valid), 64'd0);
        send_frame($urandom, 32, 0, 2, 1'b0);
        drain("flush");
        check_status("flush");

        // Reset mid-frame with three words queued
        for (int i = 0; i < 3; i++) send_frame($urandom, 32, 0, 1, 1'b0);
        send_frame($urandom, 12, 0, 1, 1'b0);
        do_reset();
        @(negedge tb_ACLK);
        check_val("arst_level", 64'(fifo_level), 64'd0);
        check_val("arst_valid", 64'(u_if.m_valid), 64'd0);
        check_status("arst");
        send_frame($urandom, 32, 0, 2, 1'b0);
        drain("arst");
        check_status("arst_after");

        // Random mix: truncations, enable drops, patterns, random ready; counters saturate
        do_clr();
        rnd_rdy = 1'b1;
        seq = $urandom;
        for (int k = 0; k < 26; k++) begin
            r = $urandom_range(0, 7);
            if (r == 0) begin
                send_frame($urandom, $urandom_range(1, 31), 0, 3, 1'b0);
            end else if (r == 1) begin
                send_frame($urandom, $urandom_range(1, 31), 0, 3, 1'b0);
                enable = 1'b0;
                step();
                enable = 1'b1;
                m_in_frame = 1'b0;
            end else if (r < 5) begin
                send_frame(seq, 32, 0, 3, 1'b0);
                seq = seq + 32'd1;
            end else begin
                send_frame($urandom, 32, 0, 3, 1'b0);
            end
        end
        drain("rand");
        check_status("rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gyro_rx_deframer.md
# gyro_rx_deframer

Receive-side deframer for the gyro serial link. Samples the DRX data line and DSYNC frame marker on a bit-rate strobe, assembles 32-bit MSB-first words, and buffers them in a small FIFO. The FIFO drains through a valid/ready stream to the capture/DMA path. Sits directly downstream of the DRX/DSYNC pins, after the pin synchronizers and the bit-clock divider. Supplies the words that the loop and RX-pattern results files are built from.

## Interface
- FIFO_DEPTH, 8: word FIFO depth; power of two, 4..64.
- CNT_W, 16: width of the frame and error counters.

- ACLK  in  1  system clock; single clock domain.
- ARESET  in  1  synchronous, active-high reset.
- enable  in  1  deframer run enable; low forces IDLE.
- flush  in  1  one-cycle pulse; empties FIFO and aborts the current frame.
- clr_status  in  1  one-cycle pulse; zeroes counters and the sticky overflow flag.
- bit_en  in  1  one-cycle strobe per bit period; drx and dsync are only sampled when it is high.
- drx  in  1  serial data, already synchronized.
- dsync  in  1  frame marker, already synchronized.
- m_data  out  32  head-of-FIFO word.
- m_valid  out  1  head word valid.
- m_ready  in  1  consumer accept.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when a word is dropped because the FIFO is full.
- frame_cnt  out  CNT_W  completed words; saturating.
- sync_err_cnt  out  CNT_W  truncated frames; saturating.
- pat_err_cnt  out  CNT_W  pattern mismatches; saturating. Driven only under the macro in Configuration.
- pat_locked  out  1  pattern checker has a seed.

## Operation
- States:
  - IDLE: waiting for a frame start.
  - SHIFT: collecting the remaining bits of a word.
- Frame start:
  - In IDLE, a cycle with bit_en=1 and dsync=1 starts a frame.
  - drx in that cycle is bit 31 (MSB). bit_cnt is set to 1 and the state goes to SHIFT.
- Shifting:
  - In SHIFT, each bit_en with dsync=0 shifts drx in at the LSB and increments bit_cnt.
  - When bit_cnt reaches 32, the word is pushed, frame_cnt increments, and the state returns to IDLE.
  - A dsync that lands exactly on the first bit after a completed word starts the next frame (back-to-back frames are legal).
- Resync:
  - In SHIFT, bit_en with dsync=1 before 32 bits means a truncated frame.
  - The partial word is discarded and sync_err_cnt increments.
  - The current bit becomes the MSB of a new frame, with bit_cnt=1.
- enable=0:
  - The state is held in IDLE and any partial word is discarded.
  - The FIFO keeps its contents and continues to drain.
- flush:
  - Clears the FIFO pointers and level and forces IDLE, in the same cycle.
  - Takes priority over a push or pop in that cycle.
- FIFO:
  - A push while full with no pop in the same cycle: the word is dropped and overflow is set.
  - A push while full with a pop in the same cycle: the word is accepted and the level is unchanged.
  - A push and pop in the same cycle at a non-full level: the level is unchanged.
- clr_status in the same cycle as an increment: the clear wins, and the counter reads 0.
- Counters saturate at all-ones.
- Reset values: all outputs are 0; m_data is 0; the state is IDLE.

## Timing
- Push latency: the word is written on the ACLK edge that ends the cycle in which the 32nd bit_en is high.
- m_valid and m_data reflect the word one cycle after the push when the FIFO was empty. Total latency is 2 cycles from the 32nd bit_en cycle to m_valid.
- Stream handshake:
  - A pop occurs on a cycle where m_valid & m_ready.
  - m_data is stable while m_valid=1 and m_ready=0.
  - m_valid does not depend combinationally on m_ready.
- fifo_level is registered and updates on the push/pop edge.
- bit_en is never assumed periodic. The minimum spacing between strobes is 1 cycle, so strobes may be high continuously.

## Configuration
- GYRO_RX_PAT_CHECK_EN defined:
  - The checker expects an incrementing 32-bit pattern on pushed words.
  - The first pushed word after reset, clr_status, or flush seeds the expected value to word+1 and sets pat_locked.
  - After that, a mismatching word increments pat_err_cnt and reseeds the expected value to received word+1.
  - The expected value wraps from 0xFFFFFFFF to 0.
  - Words dropped on overflow are not checked.
- GYRO_RX_PAT_CHECK_EN undefined: pat_err_cnt is tied to 0, pat_locked is tied to 0, and no checker logic is present.

## Structure
- Shared package gyro_rx_pkg holds:
  - the state enum (IDLE, SHIFT);
  - the WORD_W=32 constant;
  - the default FIFO_DEPTH and CNT_W.
- Sub-module gyro_word_fifo is a synchronous FIFO with registered output, level, full/empty, and flush. It is instantiated once.
- The deframer FSM, counters and pattern checker live in gyro_rx_deframer.

## Test plan
- Single frame 0xA5C3_0F1E, bit_en every 4 cycles, dsync on the first bit -> one word 0xA5C30F1E, m_valid 2 cycles after the 32nd strobe, frame_cnt=1.
- dsync reasserted at bit 20, then a full frame 0x12345678 -> sync_err_cnt=1, one word 0x12345678, frame_cnt=1.
- 10 back-to-back frames with m_ready=0 and FIFO_DEPTH=8 -> fifo_level=8, overflow=1, and after draining exactly the first 8 words appear in order.
- Full FIFO with a pop and push in the same cycle -> no overflow, level stays 8.
- Frames 5,6,7,9,10 with GYRO_RX_PAT_CHECK_EN -> pat_locked=1, pat_err_cnt=1. Without the macro, pat_err_cnt=0.
- flush pulse mid-frame (bit 12) with 3 words queued -> fifo_level=0, m_valid=0, next full frame received correctly; ARESET mid-frame gives the same result with all counters 0.
